// File: rtl/bk_add_operand_stage_pkg.sv
// rtl/bk_add_operand_stage_pkg.sv - shared types and operand interleave for the Brent-Kung adder feed stage
package bk_add_operand_stage_pkg;

  localparam int W_DEFAULT = 12;

  typedef struct packed {
    logic [W_DEFAULT-1:0] a;
    logic [W_DEFAULT-1:0] b;
  } operand_pair_t;

  typedef struct packed {
    logic                 cout;
    logic [W_DEFAULT-1:0] sum;
  } add_result_t;

  // Adder expects bit pairs side by side: even positions carry A, odd positions carry B.
  function automatic logic [2*W_DEFAULT-1:0] interleave(input operand_pair_t p);
    logic [2*W_DEFAULT-1:0] v;
    v = '0;
    for (int i = 0; i < W_DEFAULT; i++) begin
      v[2*i]   = p.a[i];
      v[2*i+1] = p.b[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/bk_add_operand_stage_fifo.sv
// rtl/bk_add_operand_stage_fifo.sv - synchronous DEPTH-entry operand FIFO with head-of-queue output
module bk_operand_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bk_add_operand_stage.sv
// rtl/bk_add_operand_stage.sv - operand FIFO feed and registered result capture around an external Brent-Kung adder
module bk_add_operand_stage
  import bk_add_operand_stage_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [2*W-1:0]   add_in,
  input  logic [W:0]       add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_sum,
  output logic             res_cout,
  output logic [CNT_W-1:0] txn_count
);

  operand_pair_t    w_in_pair;
  operand_pair_t    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_cap;
  logic             w_consume;
  add_result_t      r_res;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_txn;

  assign w_in_pair = {in_a, in_b};
  assign w_push    = in_valid & ~w_full;
  assign w_cap     = ~w_empty & (~r_res_valid | res_ready);
  assign w_consume = r_res_valid & res_ready;

  bk_operand_fifo #(
    .DW    ($bits(operand_pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in_pair),
    .i_pop   (w_cap),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Idle adder inputs are held at zero so an empty FIFO does not toggle the carry tree.
  assign add_in = w_empty ? '0 : interleave(w_head);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_txn       <= '0;
    end else begin
      if (w_cap) begin
        r_res       <= add_result_t'(add_out);
        r_res_valid <= 1'b1;
      end else if (w_consume) begin
        r_res_valid <= 1'b0;
      end
      if (w_consume) r_txn <= r_txn + CNT_W'(1);
    end
  end

  assign in_ready  = ~w_full;
  assign res_valid = r_res_valid;
  assign res_sum   = r_res.sum;
  assign res_cout  = r_res.cout;
  assign txn_count = r_txn;

endmodule

// File: tb/tb_bk_add_operand_stage.sv
// tb/tb_bk_add_operand_stage.sv - directed and random checks of the operand stage against an arithmetic reference
module tb_bk_add_operand_stage;

  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          res_ready;

  logic          in_ready,  in_ready4;
  logic [2*W-1:0] add_in,   add_in4;
  logic [W:0]    add_out,   add_out4;
  logic          res_valid, res_valid4;
  logic [W-1:0]  res_sum,   res_sum4;
  logic          res_cout,  res_cout4;
  logic [15:0]   txn_count;
  logic [3:0]    txn_count4;

  int            n_vec = 0;
  int            n_err = 0;
  logic [W:0]    exp_q[$];
  int            model_txn = 0;
  bit            wrap_checked = 0;

  always #5 clk = ~clk;

  bk_add_operand_stage #(.W(W), .DEPTH(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_in(add_in), .add_out(add_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .txn_count(txn_count)
  );

  bk_add_operand_stage #(.W(W), .DEPTH(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .add_in(add_in4), .add_out(add_out4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_sum(res_sum4),
    .res_cout(res_cout4), .txn_count(txn_count4)
  );

  // Behavioural stand-in for the adder: pull A and B back out of the pair vector and add.
  function automatic logic [W:0] adder(input logic [2*W-1:0] v);
    logic [W-1:0] a, b;
    for (int i = 0; i < W; i++) begin
      a[i] = v[2*i];
      b[i] = v[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign add_out  = adder(add_in);
  assign add_out4 = adder(add_in4);

  function automatic logic [2*W-1:0] pairs(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] v;
    for (int i = 0; i < W; i++) v[2*i +: 2] = {b[i], a[i]};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes just before the edge, return 1 time unit after it.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      model_txn = 0;
    end else begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", {res_cout, res_sum}, 32'hDEAD);
        else chk("result_order", {res_cout, res_sum}, exp_q.pop_front());
        model_txn++;
      end
      if (in_valid && in_ready) exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_txn", txn_count, 0);
    chk("rst_sum", {res_cout, res_sum}, 0);
    chk("rst_add_in_zero", add_in, 0);

    // Single op with latency and interleave check
    res_ready = 1'b1;
    send(12'h123, 12'h456);
    chk("single_add_in", add_in, pairs(12'h123, 12'h456));
    chk("single_not_yet", res_valid, 0);
    tick();
    chk("single_valid", res_valid, 1);
    chk("single_sum", res_sum, 12'h579);
    chk("single_cout", res_cout, 0);
    tick();
    chk("single_txn", txn_count, 1);
    chk("single_add_in_idle", add_in, 0);

    // Carry-out corner cases
    send(12'hFFF, 12'h001);
    tick();
    chk("ovf1_res", {res_cout, res_sum}, 13'h1000);
    tick();
    send(12'hFFF, 12'hFFF);
    tick();
    chk("ovf2_res", {res_cout, res_sum}, 13'h1FFE);
    tick();

    // Backpressure: two buffered plus one held fills the stage
    res_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 12'(i * 16'h111 + 1); in_b = 12'(i * 16'h0F3 + 7);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_held_valid", res_valid, 1);
    tick(); tick();
    chk("bp_held_sum", {res_cout, res_sum}, 13'h0008);
    chk("bp_txn_held", txn_count, 3);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_txn_after", txn_count, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset with two pairs buffered and a pending result
    res_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 12'($urandom); in_b = 12'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_full", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_res_valid", res_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_txn", txn_count, 0);
    chk("mid_add_in", add_in, 0);
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", res_valid, 0);
    end

    // Streaming random pairs at full rate; small counter checked as it wraps
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_a = 12'($urandom); in_b = 12'($urandom);
      tick();
      if (i >= 1) chk("stream_no_bubble", res_valid, 1);
      chk("stream_in_ready", in_ready, 1);
      if (model_txn == 17 && !wrap_checked) begin
        wrap_checked = 1;
        chk("wrap_txn4", txn_count4, 1);
        chk("wrap_txn16", txn_count, 17);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stream_txn", txn_count, 32'(model_txn));
    chk("stream_txn_value", txn_count, 100);
    chk("stream_txn4", txn_count4, 32'(model_txn % 16));
    chk("stream_drained", exp_q.size(), 0);
    chk("wrap_seen", wrap_checked, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
